// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single port of a 64x8 synchronous RAM.
// After every reset it walks all 64 addresses writing 0x00 before granting anything.
module ram_port_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_valid,
   input  logic       a_we,
   input  logic [5:0] a_addr,
   input  logic [7:0] a_wdata,
   output logic       a_ready,
   output logic       a_rsp_valid,
   output logic [7:0] a_rsp_data,
   input  logic       b_valid,
   input  logic       b_we,
   input  logic [5:0] b_addr,
   input  logic [7:0] b_wdata,
   output logic       b_ready,
   output logic       b_rsp_valid,
   output logic [7:0] b_rsp_data,
   output logic       ram_we,
   output logic [5:0] ram_waddr,
   output logic [5:0] ram_raddr,
   output logic [7:0] ram_din,
   input  logic [7:0] ram_dout,
   output logic       init_done
);

   typedef enum logic {INIT, RUN} state_t;

   state_t     state, state_next;
   logic [5:0] clr_cnt, clr_cnt_next;
   logic       prio, prio_next;
   logic       rd_pend, rd_accept;
   logic       rd_owner, rd_owner_next;
   logic [5:0] waddr_q, raddr_q;
   logic [7:0] din_q;
   logic       run;
   logic       grant_a, grant_b;
   logic       sel_we;
   logic [5:0] sel_addr;
   logic [7:0] sel_wdata;

   // Reset wins over everything in its own cycle, so no grant is issued while rst is high.
   assign run       = (state == RUN) && !rst;
   assign grant_a   = run && a_valid && (!b_valid || !prio);
   assign grant_b   = run && b_valid && (!a_valid ||  prio);
   assign sel_we    = grant_a ? a_we    : b_we;
   assign sel_addr  = grant_a ? a_addr  : b_addr;
   assign sel_wdata = grant_a ? a_wdata : b_wdata;

   assign a_ready   = grant_a;
   assign b_ready   = grant_b;
   assign init_done = (state == RUN) && !rst;

   // A pending response is suppressed in the reset cycle itself.
   assign a_rsp_valid = rd_pend && !rd_owner && !rst;
   assign b_rsp_valid = rd_pend &&  rd_owner && !rst;
   assign a_rsp_data  = a_rsp_valid ? ram_dout : 8'h00;
   assign b_rsp_data  = b_rsp_valid ? ram_dout : 8'h00;

   // Next-state, RAM port drive and arbitration bookkeeping; idle RAM addresses/data hold.
   always_comb begin
      state_next    = state;
      clr_cnt_next  = clr_cnt;
      prio_next     = prio;
      rd_accept     = 1'b0;
      rd_owner_next = rd_owner;
      ram_we        = 1'b0;
      ram_waddr     = waddr_q;
      ram_raddr     = raddr_q;
      ram_din       = din_q;
      case (state)
         INIT: begin
            ram_we       = 1'b1;
            ram_waddr    = clr_cnt;
            ram_din      = 8'h00;
            clr_cnt_next = clr_cnt + 6'd1;
            if (clr_cnt == 6'd63) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (grant_a || grant_b) begin
               prio_next = grant_a;
               if (sel_we) begin
                  ram_we    = 1'b1;
                  ram_waddr = sel_addr;
                  ram_din   = sel_wdata;
               end else begin
                  ram_raddr     = sel_addr;
                  rd_accept     = 1'b1;
                  rd_owner_next = grant_b;
               end
            end
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   // State register; the last driven RAM address/data are kept for idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         clr_cnt  <= 6'd0;
         prio     <= 1'b0;
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
         waddr_q  <= 6'd0;
         raddr_q  <= 6'd0;
         din_q    <= 8'h00;
      end else begin
         state    <= state_next;
         clr_cnt  <= clr_cnt_next;
         prio     <= prio_next;
         rd_pend  <= rd_accept;
         rd_owner <= rd_owner_next;
         waddr_q  <= ram_waddr;
         raddr_q  <= ram_raddr;
         din_q    <= ram_din;
      end
   end

endmodule
